multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Iterative signed 32-bit multiply/divide unit; the responder side of the pipeline's multdiv request interface.
- The X stage pulses ctrl_MULT or ctrl_DIV with operands; this block computes one bit per cycle and returns the result with a one-cycle data_resultRDY pulse.
- The pipeline stalls on it until that pulse.
- Fixed, data-independent latency, so stall logic can be a simple wait-for-RDY.

Parameters:
WIDTH, 32, operand/result width; counter width is clog2(WIDTH)+1.

Ports:
clock  input  1  master clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  start multiply; sampled on the rising edge
ctrl_DIV  input  1  start divide; sampled on the rising edge
data_result  output  WIDTH  product low word or quotient; registered
data_exception  output  1  overflow / divide-by-zero flag; registered, valid when data_resultRDY=1
data_resultRDY  output  1  one-cycle pulse: result valid
busy  output  1  1 while in RUN or FIX

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0. Internal operand/accumulator registers are cleared.
- States:
  - IDLE: waits for a start.
  - RUN: WIDTH iterations.
  - FIX: sign correction and exception evaluation.
  - DONE: outputs held; RDY pulse.
- Start:
  - At any edge where ctrl_MULT|ctrl_DIV=1, latch operands and op, set counter=0, go to RUN. This edge is E0.
  - This applies in every state. A start during RUN/FIX aborts the current operation with no RDY for it, and restarts.
  - If both are high, MULT wins and DIV is ignored.
- RUN, MULT:
  - Radix-2 shift-add on the magnitudes |A|, |B| in a 2*WIDTH product register; one bit per edge.
- RUN, DIV:
  - Restoring division on |A|, |B|; shift remainder:quotient left, trial-subtract, set quotient bit.
  - One bit per edge.
- RUN ends: after edge E_WIDTH (E32), go to FIX.
- FIX (edge E33):
  - Apply sign: negate if sign(A) XOR sign(B).
  - Register data_result and data_exception, assert data_resultRDY.
  - Go to DONE.
- Latency: data_resultRDY=1 for exactly the one cycle following E33; deasserted at E34.
- DONE: data_result and data_exception hold until the next start or reset. In DONE with no start, the block returns to IDLE; outputs are still held and busy=0.
- busy: 1 from after E0 through E33 inclusive; 0 once RDY is asserted.
- MULT result: low WIDTH bits of the signed 2*WIDTH product. data_exception=1 iff the full signed product is not representable in WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal.
- DIV result:
  - Quotient truncated toward zero; remainder discarded.
  - B=0: data_result=0, data_exception=1. Timing is unchanged (RDY still after E33).
  - A=0x80000000, B=-1: data_result=0x80000000, data_exception=1.
  - Otherwise data_exception=0.
- Operand inputs are ignored except at a start edge. Changing them mid-operation has no effect.
- Reset mid-operation: the operation is abandoned, all outputs clear immediately, and no RDY is produced.

Test Plan:
- MULT A=7, B=-3 at E0 -> after E33: data_result=0xFFFFFFEB, data_exception=0, RDY high exactly 1 cycle. busy=1 from after E0 through E33.
- DIV A=-100, B=7 -> data_result=0xFFFFFFF2 (-14), data_exception=0. DIV A=0x80000000, B=-1 -> 0x80000000, data_exception=1.
- DIV A=5, B=0 -> after E33: data_result=0, data_exception=1. MULT A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1.
- MULT A=3, B=4 started; at E10 start DIV A=20, B=4 -> no RDY for the MULT. RDY exactly 33 edges after the DIV start, data_result=5.
- ctrl_MULT and ctrl_DIV both high with A=6, B=2 -> data_result=12 (multiply). Then hold inputs idle for 5 cycles -> result stays 12, RDY stays 0.
- Assert reset=0 asynchronously at E20 of a MULT -> outputs go to 0 immediately, with no clock edge. Release reset, run no start for 40 cycles -> RDY never asserts.

Source files
------------

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply/divide, one bit per cycle, fixed 34-cycle latency
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag;
  logic               is_mult, neg, b_zero;
  logic               start;
  logic [WIDTH-1:0]   a_abs, b_abs, quo, res_n;
  logic [WIDTH:0]     add_sum, sub;
  logic [2*WIDTH-1:0] shl, step, prod;
  logic               exc_n;
  // Datapath: mult shifts the product right with a conditional add of |A| into the upper half;
  // div shifts remainder:quotient left and keeps the trial subtract of |B| when it does not borrow.
  // mag holds |A| for multiply and |B| for divide, so one register serves both.
  always_comb begin
    start   = ctrl_MULT | ctrl_DIV;
    a_abs   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_abs   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag};
    shl     = {acc[2*WIDTH-2:0], 1'b0};
    sub     = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, mag};
    step    = is_mult ? (acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]})
                      : (sub[WIDTH] ? shl : {sub[WIDTH-1:0], shl[WIDTH-1:1], 1'b1});
    prod    = neg ? -acc : acc;
    quo     = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    res_n   = is_mult ? prod[WIDTH-1:0] : (b_zero ? '0 : quo);
    exc_n   = is_mult ? !(&prod[2*WIDTH-1:WIDTH-1] | ~|prod[2*WIDTH-1:WIDTH-1])
                      : (b_zero | (!neg & acc[WIDTH-1]));
  end
  // Control FSM: a start in any state restarts; RUN iterates WIDTH times, FIX publishes the result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mag            <= '0;
      is_mult        <= 1'b0;
      neg            <= 1'b0;
      b_zero         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (start) begin
      state          <= RUN;
      cnt            <= '0;
      is_mult        <= ctrl_MULT;
      neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      b_zero         <= data_operandB == '0;
      mag            <= ctrl_MULT ? a_abs : b_abs;
      acc            <= {{WIDTH{1'b0}}, ctrl_MULT ? b_abs : a_abs};
      data_resultRDY <= 1'b0;
    end else if (state == RUN) begin
      acc   <= step;
      cnt   <= cnt + 1'b1;
      state <= cnt == LAST ? FIX : RUN;
    end else if (state == FIX) begin
      data_result    <= res_n;
      data_exception <= exc_n;
      data_resultRDY <= 1'b1;
      state          <= DONE;
    end else begin
      data_resultRDY <= 1'b0;
      state          <= IDLE;
    end
  end
  assign busy = (state == RUN) || (state == FIX);
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: directed tests against an arithmetic reference model with per-cycle compare
module tb_multdiv_iter;
  logic        clock, reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  int          n_cmp = 0, n_bad = 0;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic logic [32:0] ref_op(input logic m, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb, q;
    logic [31:0] lo;
    if (m) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), lo};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    return {1'b0, q};
  endfunction

  logic        m_pend, m_rdy, m_busy, m_exc, m_texc;
  logic [31:0] m_res, m_tres;
  int          m_k;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pend <= 0; m_k <= 0; m_res <= 0; m_exc <= 0; m_rdy <= 0; m_busy <= 0;
      m_tres <= 0; m_texc <= 0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      {m_texc, m_tres} <= ref_op(ctrl_MULT, data_operandA, data_operandB);
      m_pend <= 1; m_k <= 1; m_rdy <= 0; m_busy <= 1;
    end else if (m_pend && m_k == 33) begin
      m_pend <= 0; m_res <= m_tres; m_exc <= m_texc; m_rdy <= 1; m_busy <= 0;
    end else begin
      m_rdy <= 0;
      if (m_pend) m_k <= m_k + 1;
    end
  end

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      check("mon_result", {1'b0, data_result}, {1'b0, m_res});
      check("mon_exc", {32'd0, data_exception}, {32'd0, m_exc});
      check("mon_rdy", {32'd0, data_resultRDY}, {32'd0, m_rdy});
      check("mon_busy", {32'd0, busy}, {32'd0, m_busy});
    end
  end

  task automatic go(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_done(input logic [31:0] er, input logic ee, input string nm);
    int n = 0;
    while (!data_resultRDY && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_lat"}, 33'(n), 33'd33);
    check({nm, "_res"}, {1'b0, data_result}, {1'b0, er});
    check({nm, "_exc"}, {32'd0, data_exception}, {32'd0, ee});
    @(negedge clock);
    check({nm, "_rdy_off"}, {32'd0, data_resultRDY}, 33'd0);
  endtask

  task automatic op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] er, input logic ee, input string nm);
    go(m, d, a, b);
    wait_done(er, ee, nm);
  endtask

  initial begin
    int rdy_seen;
    reset = 0; ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 0; data_operandB = 0;
    repeat (2) @(negedge clock);
    check("rst_result", {1'b0, data_result}, 33'd0);
    check("rst_flags", {30'd0, data_exception, data_resultRDY, busy}, 33'd0);
    reset = 1;
    @(negedge clock);
    op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_m3");
    op(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, "div_m100_7");
    op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_min_m1");
    op(0, 1, 32'd5, 32'd0, 32'd0, 1, "div_by0");
    op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, "mul_ovf");
    op(1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, "mul_min_1");
    op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "mul_min_m1");
    op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, "mul_m1_m1");
    op(0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, "div_7_m2");
    op(0, 1, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, "div_min_1");
    go(1, 0, 32'd3, 32'd4);
    repeat (9) begin
      check("abort_no_rdy", {32'd0, data_resultRDY}, 33'd0);
      @(negedge clock);
    end
    op(0, 1, 32'd20, 32'd4, 32'd5, 0, "abort_div");
    op(1, 1, 32'd6, 32'd2, 32'd12, 0, "both_mult");
    repeat (5) begin
      @(negedge clock);
      check("idle_hold", {data_resultRDY, data_result}, {1'b0, 32'd12});
    end
    go(1, 0, 32'd7, 32'd3);
    repeat (19) @(negedge clock);
    @(posedge clock);
    #1 reset = 0;
    #1;
    check("async_rst_result", {1'b0, data_result}, 33'd0);
    check("async_rst_flags", {30'd0, data_exception, data_resultRDY, busy}, 33'd0);
    @(negedge clock);
    reset = 1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("post_rst_no_rdy", 33'(rdy_seen), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
